// File: rtl/dm_mover_if.sv
// Request/status/memory-port bundle between a requester and the dm_mover block.
interface dm_mover_if #(
  parameter int AW = 10,
  parameter int LW = 9
);
  // request side
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic [31:0]   fill_data;
  logic          abort;
  // status side
  logic          ready;
  logic          done;
  logic          err;
  logic          aborted;
  logic [LW-1:0] words_done;
  // data memory port
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  modport master (
    output start, mode, src_addr, dst_addr, len, fill_data, abort,
    input  ready, done, err, aborted, words_done,
    input  mem_addr, mem_we, mem_din,
    output mem_dout
  );

  modport slave (
    input  start, mode, src_addr, dst_addr, len, fill_data, abort,
    output ready, done, err, aborted, words_done,
    output mem_addr, mem_we, mem_din,
    input  mem_dout
  );
endinterface

// File: rtl/dm_mover.sv
// Word-granular COPY/FILL engine for the data memory port. One word per
// RD+WR pair in COPY, one word per WR cycle in FILL, then a one-cycle done.
module dm_mover #(
  parameter int AW = 10,
  parameter int LW = 9
) (
  input  logic      clk,
  input  logic      rst_n,
  dm_mover_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [LW-1:0] MAX_LEN = {1'b1, {(LW-1){1'b0}}};
  localparam logic [AW-1:0] STEP    = AW'(4);
  localparam logic [LW-1:0] ONE     = LW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] rem_q, rem_d, wdone_q, wdone_d;
  logic          mode_q, mode_d, err_q, err_d, abt_q, abt_d;
  logic [31:0]   fill_q, fill_d, buf_q, buf_d;

  // State and datapath registers; reset drops any write in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      wdone_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      wdone_q <= wdone_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic: accept/validate in IDLE, alternate RD/WR (COPY) or
  // stream WR (FILL), leave early on abort or when the count runs out.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wdone_d = wdone_q;
    mode_d  = mode_q;
    err_d   = err_q;
    abt_d   = abt_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
          rem_d   = bus.len;
          mode_d  = bus.mode;
          fill_d  = bus.fill_data;
          wdone_d = '0;
          err_d   = 1'b0;
          abt_d   = 1'b0;
          if ((!bus.mode && bus.src_addr[1:0] != 2'b00) ||
              bus.dst_addr[1:0] != 2'b00 || bus.len > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.len == '0) begin
            state_d = DONE;
          end else begin
            state_d = bus.mode ? WR : RD;
          end
        end
      end
      RD: begin
        buf_d = bus.mem_dout;
        if (bus.abort) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        wdone_d = wdone_q + ONE;
        dst_d   = dst_q + STEP;
        rem_d   = rem_q - ONE;
        if (!mode_q) src_d = src_q + STEP;
        if (bus.abort) abt_d = 1'b1;
        if (rem_q == ONE || bus.abort) state_d = DONE;
        else                           state_d = mode_q ? WR : RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; nothing passes through from inputs.
  always_comb begin
    bus.ready      = (state_q == IDLE);
    bus.done       = (state_q == DONE);
    bus.err        = err_q;
    bus.aborted    = abt_q;
    bus.words_done = wdone_q;
    bus.mem_we     = (state_q == WR);
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    if (state_q == RD) bus.mem_addr = src_q;
    if (state_q == WR) begin
      bus.mem_addr = dst_q;
      bus.mem_din  = mode_q ? fill_q : buf_q;
    end
  end

endmodule
